div_req_scheduler: RTL and testbench
====================================

DIV_REQ_SCHEDULER -- requirements
Module: div_req_scheduler

Interface
REQ-001 Parameters SHALL be:
- TAMANYO, default 32, operand width.
- NREQ, default 4, number of requesters.
- LAT, default 2*TAMANYO+1, cycles from divider Start to Done.
REQ-002 Ports SHALL be, in this order:
- CLK  in  1  clock.
- RSTa  in  1  reset, asynchronous, active-low.
- en  in  1  scheduler enable.
- req_valid  in  NREQ  per-requester request valid.
- req_num  in  NREQ*TAMANYO  signed dividends, slot i = requester i.
- req_den  in  NREQ*TAMANYO  signed divisors, slot i = requester i.
- req_ready  out  NREQ  one-hot grant.
- div_start  out  1  divider Start.
- div_num  out  TAMANYO  divider Num.
- div_den  out  TAMANYO  divider Den.
- div_coc  in  TAMANYO  divider Coc.
- div_res  in  TAMANYO  divider Res.
- div_done  in  1  divider Done.
- rsp_valid  out  1  response valid.
- rsp_id  out  clog2(NREQ)  response requester index.
- rsp_coc  out  TAMANYO  quotient.
- rsp_res  out  TAMANYO  remainder.
- rsp_err  out  1  divide-by-zero flag.
- occ  out  clog2(LAT+1)  operations in flight.
- idle  out  1  scheduler in IDLE state.
- sync_err  out  1  sticky tag/Done mismatch.

Function
REQ-003 The block SHALL share one fully pipelined divider among NREQ requesters, issuing at most one operation per cycle.
REQ-004 req_ready SHALL be combinational from req_valid, the round-robin pointer and the state, and SHALL have at most one bit set.
REQ-005 Transfer on requester i SHALL occur when req_valid[i] and req_ready[i] are both 1; a requester SHALL keep valid and data stable until transfer.
REQ-006 Arbitration SHALL be round-robin: search starts at pointer+1 modulo NREQ; after a transfer the pointer SHALL equal the granted index; with no transfer the pointer SHALL hold.
REQ-007 In the cycle of a transfer:
- div_start SHALL be 1 and div_num/div_den SHALL equal the granted operands.
- Otherwise div_start SHALL be 0 and div_num/div_den SHALL be 0.
REQ-008 A LAT-deep tag shift register SHALL advance every cycle, carrying {valid, id, dz} where dz=(den==0); a transfer inserts valid=1, otherwise valid=0.
REQ-009 When the tag leaving stage LAT is valid:
- rsp_valid SHALL be 1 and rsp_id SHALL equal the tag id.
- If dz=0: rsp_coc=div_coc, rsp_res=div_res, rsp_err=0.
- If dz=1: rsp_coc=0, rsp_res=0, rsp_err=1.
- Response latency SHALL therefore be exactly LAT cycles after transfer.
REQ-010 When no valid tag exits, rsp_valid, rsp_err, rsp_id, rsp_coc and rsp_res SHALL all be 0; there is no response backpressure.
REQ-011 sync_err SHALL set when div_done differs from the exiting tag valid bit, and SHALL hold until reset.
REQ-012 occ SHALL increment on transfer and decrement on a valid exiting tag; with both in the same cycle it SHALL be unchanged; it never exceeds LAT.
REQ-013 The FSM SHALL have states IDLE, RUN and DRAIN:
- IDLE->RUN when en=1.
- RUN->DRAIN when en=0.
- DRAIN->IDLE when occ==0, evaluated after any exit in that cycle.
- DRAIN->RUN when en=1.
REQ-014 Grants SHALL occur only in RUN; IDLE and DRAIN SHALL keep req_ready=0 while in-flight responses are still delivered.
REQ-015 idle SHALL be 1 only in IDLE.

Reset
REQ-016 RSTa low SHALL asynchronously set:
- state to IDLE and pointer to NREQ-1.
- all tags invalid, occ=0 and sync_err=0.
- every output to 0 except idle, which is 1.
REQ-017 Reset mid-operation SHALL discard all in-flight tags; no response for them SHALL appear after release.

Verification
REQ-018 Directed scenarios, defaults TAMANYO=32, NREQ=4, LAT=65:
- Reset, en=1, req 0 alone with 100/7 -> req_ready=0001 same cycle; rsp_valid 65 cycles later with id=0, coc=14, res=2, err=0.
- All four valid continuously, en=1 -> grants 0,1,2,3,0,... one per cycle; occ reaches 65 and holds; responses return in grant order.
- Req 2 with -100/7 then 100/-7 -> coc=-14,res=-2 then coc=-14,res=2.
- Req 1 with 5/0 -> rsp_err=1, coc=0, res=0, id=1 after 65 cycles.
- 10 issues then en=0 -> DRAIN, no grants, 10 responses, idle=1 once occ=0.
- RSTa low 20 cycles after an issue -> outputs 0, idle=1, no response after release; forcing div_done=1 with no valid tag -> sync_err=1 sticky.

Source files
------------

// File: rtl/div_req_scheduler.sv
`timescale 1ns/1ps
// div_req_scheduler
// Shares one fully pipelined signed divider among NREQ requesters.
// At most one operation is issued per cycle, and requesters are served round-robin.
// A LAT-deep tag pipeline travels alongside the divider. When a tag leaves the
// pipeline, its response is formed from the divider result or from the
// divide-by-zero flag carried in the tag.
//
// state   | meaning
// S_IDLE  | scheduler parked, no grants, nothing expected in flight
// S_RUN   | grants allowed, one issue per cycle at most
// S_DRAIN | no grants, waiting for in-flight operations to return
module div_req_scheduler #(
    parameter int TAMANYO = 32,
    parameter int NREQ    = 4,
    parameter int LAT     = 2*TAMANYO+1
) (
    input  logic                          CLK,
    input  logic                          RSTa,
    input  logic                          en,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ*TAMANYO-1:0]       req_num,
    input  logic [NREQ*TAMANYO-1:0]       req_den,
    output logic [NREQ-1:0]               req_ready,
    output logic                          div_start,
    output logic [TAMANYO-1:0]            div_num,
    output logic [TAMANYO-1:0]            div_den,
    input  logic [TAMANYO-1:0]            div_coc,
    input  logic [TAMANYO-1:0]            div_res,
    input  logic                          div_done,
    output logic                          rsp_valid,
    output logic [$clog2(NREQ)-1:0]       rsp_id,
    output logic [TAMANYO-1:0]            rsp_coc,
    output logic [TAMANYO-1:0]            rsp_res,
    output logic                          rsp_err,
    output logic [$clog2(LAT+1)-1:0]      occ,
    output logic                          idle,
    output logic                          sync_err
);

    localparam int IDW = $clog2(NREQ);
    localparam int OCW = $clog2(LAT+1);
    localparam logic [IDW:0]   NREQ_W   = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] PTR_INIT = IDW'(NREQ-1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [IDW-1:0]     ptr;

    logic [IDW:0]       cand;
    logic               grant_hit;
    logic [IDW-1:0]     grant_idx;
    logic [TAMANYO-1:0] gnt_num;
    logic [TAMANYO-1:0] gnt_den;
    logic               gnt_dz;

    logic [LAT:1]       tag_v;
    logic [LAT:1]       tag_dz;
    logic [IDW-1:0]     tag_id [1:LAT];

    logic               exit_v;
    logic               exit_dz;
    logic [IDW-1:0]     exit_id;
    logic [OCW-1:0]     occ_nxt;

    // Round-robin search starting one past the last granted requester; only in RUN.
    // The candidate sum is below 2*NREQ, so a single conditional subtract wraps it.
    always_comb begin
        grant_hit = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (state == S_RUN) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = {1'b0, ptr} + (IDW+1)'(k);
                if (cand >= NREQ_W) begin
                    cand = cand - NREQ_W;
                end
                if (!grant_hit && req_valid[cand[IDW-1:0]]) begin
                    grant_hit = 1'b1;
                    grant_idx = cand[IDW-1:0];
                end
            end
        end
    end

    assign gnt_num = req_num[grant_idx*TAMANYO +: TAMANYO];
    assign gnt_den = req_den[grant_idx*TAMANYO +: TAMANYO];
    assign gnt_dz  = (gnt_den == '0);

    // One-hot grant and divider launch; operands are forced to zero when nothing is issued
    always_comb begin
        req_ready = '0;
        div_start = grant_hit;
        div_num   = '0;
        div_den   = '0;
        if (grant_hit) begin
            req_ready[grant_idx] = 1'b1;
            div_num              = gnt_num;
            div_den              = gnt_den;
        end
    end

    // Round-robin pointer follows the last granted requester
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            ptr <= PTR_INIT;
        end else if (grant_hit) begin
            ptr <= grant_idx;
        end
    end

    // Tag pipeline runs in lockstep with the divider, so stage LAT lines up with Done
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            tag_v  <= '0;
            tag_dz <= '0;
            for (int i = 1; i <= LAT; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_v[1]  <= grant_hit;
            tag_dz[1] <= grant_hit & gnt_dz;
            tag_id[1] <= grant_idx;
            for (int i = 2; i <= LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_dz[i] <= tag_dz[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    assign exit_v  = tag_v[LAT];
    assign exit_dz = tag_dz[LAT];
    assign exit_id = tag_id[LAT];

    // Response formed from the exiting tag; divide-by-zero results are masked to zero
    always_comb begin
        rsp_valid = exit_v;
        rsp_id    = '0;
        rsp_coc   = '0;
        rsp_res   = '0;
        rsp_err   = 1'b0;
        if (exit_v) begin
            rsp_id = exit_id;
            if (exit_dz) begin
                rsp_err = 1'b1;
            end else begin
                rsp_coc = div_coc;
                rsp_res = div_res;
            end
        end
    end

    // Next occupancy: an issue and a retirement in the same cycle cancel out
    always_comb begin
        occ_nxt = occ;
        if (grant_hit && !exit_v) begin
            occ_nxt = occ + 1'b1;
        end else if (!grant_hit && exit_v) begin
            occ_nxt = occ - 1'b1;
        end
    end

    // Occupancy register
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            occ <= '0;
        end else begin
            occ <= occ_nxt;
        end
    end

    // Sticky flag when the divider Done disagrees with the exiting tag
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            sync_err <= 1'b0;
        end else if (div_done != exit_v) begin
            sync_err <= 1'b1;
        end
    end

    // Scheduler FSM with registered idle flag; DRAIN exits on occupancy after this cycle's retirement
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state <= S_IDLE;
            idle  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (en) begin
                        state <= S_RUN;
                        idle  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!en) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (en) begin
                        state <= S_RUN;
                    end else if (occ_nxt == '0) begin
                        state <= S_IDLE;
                        idle  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_req_scheduler.sv
`timescale 1ns/1ps
// Bench for div_req_scheduler.
// It contains a pipelined divider model and a reference model of the scheduler.
// The scheduler model is written as a queue of expected responses, each
// stamped with its due cycle.
module tb_div_req_scheduler;

    localparam int TAMANYO = 32;
    localparam int NREQ    = 4;
    localparam int LAT     = 2*TAMANYO+1;

    logic                     CLK = 1'b0;
    logic                     RSTa = 1'b0;
    logic                     en = 1'b0;
    logic [NREQ-1:0]          req_valid = '0;
    logic [NREQ*TAMANYO-1:0]  req_num = '0;
    logic [NREQ*TAMANYO-1:0]  req_den = '0;
    logic [NREQ-1:0]          req_ready;
    logic                     div_start;
    logic [TAMANYO-1:0]       div_num;
    logic [TAMANYO-1:0]       div_den;
    logic [TAMANYO-1:0]       div_coc;
    logic [TAMANYO-1:0]       div_res;
    logic                     div_done;
    logic                     rsp_valid;
    logic [1:0]               rsp_id;
    logic [TAMANYO-1:0]       rsp_coc;
    logic [TAMANYO-1:0]       rsp_res;
    logic                     rsp_err;
    logic [6:0]               occ;
    logic                     idle;
    logic                     sync_err;

    always #5 CLK = ~CLK;

    div_req_scheduler #(.TAMANYO(TAMANYO), .NREQ(NREQ), .LAT(LAT)) dut (
        .CLK(CLK), .RSTa(RSTa), .en(en),
        .req_valid(req_valid), .req_num(req_num), .req_den(req_den),
        .req_ready(req_ready),
        .div_start(div_start), .div_num(div_num), .div_den(div_den),
        .div_coc(div_coc), .div_res(div_res), .div_done(div_done),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_coc(rsp_coc),
        .rsp_res(rsp_res), .rsp_err(rsp_err),
        .occ(occ), .idle(idle), .sync_err(sync_err)
    );

    // divider model: LAT-stage pipeline, garbage on outputs when not a real result
    bit  dv [1:LAT];
    int  dc [1:LAT];
    int  dr [1:LAT];
    bit  force_done = 1'b0;
    assign div_done = dv[LAT] | force_done;
    assign div_coc  = dc[LAT];
    assign div_res  = dr[LAT];

    // reference model
    typedef struct { int due; int id; int coc; int res; bit err; } rsp_t;
    typedef enum int { M_IDLE, M_RUN, M_DRAIN } mst_t;
    rsp_t q[$];
    mst_t mstate;
    int   mptr;
    bit   msync;

    bit   pv [NREQ];
    int   pn [NREQ];
    int   pd [NREQ];

    int n_chk = 0, n_err = 0, cyc = 0, n_grant = 0, n_rsp = 0;
    int last_g = -1, x_cyc = 0;
    int o_cyc = 0, o_id = 0, o_coc = 0, o_res = 0, o_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i] = pv[i];
            req_num[i*TAMANYO +: TAMANYO] = pn[i];
            req_den[i*TAMANYO +: TAMANYO] = pd[i];
        end
    endtask

    task automatic rst_model();
        q.delete();
        mstate = M_IDLE;
        mptr   = NREQ-1;
        msync  = 1'b0;
        for (int i = 1; i <= LAT; i++) dv[i] = 1'b0;
    endtask

    task automatic refill(input int i);
        pv[i] = 1'b1;
        pn[i] = int'($urandom_range(0, 2000000)) - 1000000;
        pd[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 2000)) - 1000;
    endtask

    // one clock cycle: check at negedge, advance the models, then drive new inputs after the edge
    task automatic cycle();
        int g;
        bit ex;
        logic [NREQ-1:0] er;
        bit cs;
        int cn, cd;
        rsp_t e;
        @(negedge CLK);
        if (!RSTa) rst_model();
        g = -1;
        if (RSTa && mstate == M_RUN) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (mptr + k) % NREQ;
                if (g < 0 && pv[c]) g = c;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ex = (q.size() > 0) && (q[0].due == cyc);
        chk("req_ready", req_ready, er);
        chk("div_start", div_start, (g >= 0));
        chk("div_num", div_num, (g >= 0) ? pn[g] : 0);
        chk("div_den", div_den, (g >= 0) ? pd[g] : 0);
        chk("rsp_valid", rsp_valid, ex);
        chk("rsp_id", rsp_id, ex ? q[0].id : 0);
        chk("rsp_coc", rsp_coc, ex ? q[0].coc : 0);
        chk("rsp_res", rsp_res, ex ? q[0].res : 0);
        chk("rsp_err", rsp_err, ex ? q[0].err : 0);
        chk("occ", occ, q.size());
        chk("idle", idle, (mstate == M_IDLE));
        chk("sync_err", sync_err, msync);
        if (rsp_valid) begin
            o_cyc = cyc; o_id = rsp_id; o_coc = rsp_coc; o_res = rsp_res; o_err = rsp_err;
        end
        cs = div_start;
        cn = div_num;
        cd = div_den;
        if (RSTa) begin
            if (div_done != ex) msync = 1'b1;
            if (ex) begin
                void'(q.pop_front());
                n_rsp++;
            end
            if (g >= 0) begin
                e.due = cyc + LAT;
                e.id  = g;
                e.err = (pd[g] == 0);
                e.coc = e.err ? 0 : pn[g] / pd[g];
                e.res = e.err ? 0 : pn[g] % pd[g];
                q.push_back(e);
                mptr = g;
                pv[g] = 1'b0;
                n_grant++;
                last_g = g;
                x_cyc = cyc;
            end
            case (mstate)
                M_IDLE:  if (en) mstate = M_RUN;
                M_RUN:   if (!en) mstate = M_DRAIN;
                M_DRAIN: if (en) mstate = M_RUN; else if (q.size() == 0) mstate = M_IDLE;
                default: mstate = M_IDLE;
            endcase
        end
        @(posedge CLK);
        #1;
        for (int i = LAT; i >= 2; i--) begin
            dv[i] = dv[i-1]; dc[i] = dc[i-1]; dr[i] = dr[i-1];
        end
        dv[1] = cs;
        if (cs && cd != 0) begin
            dc[1] = cn / cd; dr[1] = cn % cd;
        end else begin
            dc[1] = $urandom; dr[1] = $urandom;
        end
        if (!RSTa) begin
            for (int i = 1; i <= LAT; i++) dv[i] = 1'b0;
        end
        cyc++;
        drive();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic one_op(input int i, input int n, input int d);
        pv[i] = 1'b1; pn[i] = n; pd[i] = d;
        drive();
        for (int t = 0; t < 20 && pv[i]; t++) cycle();
        chk("grant_timeout", pv[i], 0);
        run(LAT + 2);
        chk("op_latency", o_cyc - x_cyc, LAT);
    endtask

    initial begin
        int ng0, nr0;
        for (int i = 1; i <= LAT; i++) begin dv[i] = 0; dc[i] = 0; dr[i] = 0; end
        for (int i = 0; i < NREQ; i++) begin pv[i] = 0; pn[i] = 0; pd[i] = 0; end
        rst_model();
        drive();
        run(3);
        RSTa = 1'b1;
        run(2);

        // single request 100/7 on requester 0
        en = 1'b1;
        run(1);
        one_op(0, 100, 7);
        chk("d0_id", o_id, 0);
        chk("d0_coc", o_coc, 14);
        chk("d0_res", o_res, 2);
        chk("d0_err", o_err, 0);

        // signed operands on requester 2
        one_op(2, -100, 7);
        chk("d2a_coc", o_coc, -14);
        chk("d2a_res", o_res, -2);
        one_op(2, 100, -7);
        chk("d2b_coc", o_coc, -14);
        chk("d2b_res", o_res, 2);

        // divide by zero on requester 1
        one_op(1, 5, 0);
        chk("dz_id", o_id, 1);
        chk("dz_err", o_err, 1);
        chk("dz_coc", o_coc, 0);
        chk("dz_res", o_res, 0);

        // saturate: all four requesters valid continuously
        for (int i = 0; i < NREQ; i++) refill(i);
        drive();
        for (int t = 0; t < 150; t++) begin
            cycle();
            for (int i = 0; i < NREQ; i++) if (!pv[i]) refill(i);
            drive();
        end
        chk("occ_full", occ, LAT);

        // random traffic with en toggling
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 19) == 0) en = ~en;
            for (int i = 0; i < NREQ; i++) if (!pv[i] && $urandom_range(0, 1) == 1) refill(i);
            drive();
            cycle();
        end

        // quiesce, then 10 issues followed by en=0
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        en = 1'b1;
        drive();
        run(LAT + 5);
        ng0 = n_grant;
        nr0 = n_rsp;
        for (int i = 0; i < NREQ; i++) refill(i);
        drive();
        for (int t = 0; t < 40 && (n_grant - ng0) < 10; t++) begin
            cycle();
            for (int i = 0; i < NREQ; i++) if (!pv[i]) refill(i);
            if (n_grant - ng0 == 9) en = 1'b0;
            drive();
        end
        for (int t = 0; t < LAT + 20 && mstate != M_IDLE; t++) cycle();
        run(3);
        chk("drain_grants", n_grant - ng0, 10);
        chk("drain_rsps", n_rsp - nr0, 10);
        chk("drain_idle", idle, 1);

        // reset 20 cycles after an issue
        en = 1'b1;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        drive();
        run(1);
        one_op(3, 77, 5);
        pv[3] = 1'b1; pn[3] = 1234; pd[3] = 11;
        drive();
        for (int t = 0; t < 10 && pv[3]; t++) cycle();
        pv[1] = 1'b1;
        drive();
        run(20);
        RSTa = 1'b0;
        nr0 = n_rsp;
        run(4);
        RSTa = 1'b1;
        en = 1'b0;
        for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
        drive();
        run(LAT + 10);
        chk("rst_no_rsp", n_rsp - nr0, 0);
        chk("rst_idle", idle, 1);

        // Done with no valid tag sets the sticky sync flag
        force_done = 1'b1;
        run(1);
        force_done = 1'b0;
        run(5);
        chk("sync_sticky", sync_err, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
